hadamard_frame_accumulator: RTL and testbench
=============================================

Name: hadamard_frame_accumulator

Overview:
- Sits directly downstream of the dual-image Hadamard multiplier and consumes its registered o_v_sync / o_h_sync / o_res_data stream.
- Sums every valid product in a frame, giving the frame-level inner product / correlation of the two IR images.
- Also counts pixels and lines and flags malformed or overflowed frames.
- Presents one registered result per frame with a single-cycle valid pulse.

Parameters:
- P_INPUT_DATA_WIDTH, 32: width of incoming product data.
- P_IMG_WIDTH, 256: expected valid pixels per line.
- P_IMG_HEIGHT, 256: expected lines per frame.
- P_SUM_WIDTH, 48: accumulator and result width. Must be >= P_INPUT_DATA_WIDTH.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_v_sync  input  1  frame-active level; high for the whole frame
- i_h_sync  input  1  pixel-valid; high while i_data is a valid product
- i_data  input  P_INPUT_DATA_WIDTH  product sample, aligned with i_h_sync
- o_sum_valid  output  1  one-cycle pulse; frame result is valid
- o_sum  output  P_SUM_WIDTH  frame sum, held until next result
- o_pix_cnt  output  clog2(P_IMG_WIDTH*P_IMG_HEIGHT+1)  valid pixels counted in the frame, held
- o_line_cnt  output  clog2(P_IMG_HEIGHT+1)  lines counted in the frame, held
- o_frame_err  output  1  result flag, held; 1 = count mismatch or saturation
- o_busy  output  1  high while state is ACCUM

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Internal accumulator, counters and saturation flag cleared.
- Input stage: i_v_sync, i_h_sync and i_data are registered once (r_v, r_h, r_d). r_v_d is the previous r_v.
- r_v_d resets to 1. A frame already in progress when reset is released is therefore never seen as a rising edge and is ignored.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - r_v & !r_v_d -> ACCUM.
  - On that transition, clear the accumulator, pixel counter, line counter and saturation flag.
  - If r_h is also 1 in that cycle, the first pixel is accumulated into the cleared accumulator.
- ACCUM, while r_v = 1:
  - Each cycle with r_h = 1: acc <= acc + zero-extended r_d.
  - Overflow beyond P_SUM_WIDTH clamps acc to all-ones and sets the sticky saturation flag.
  - Pixel counter increments and saturates at its maximum.
  - Line counter increments on each r_h falling edge (r_h_d & !r_h) and saturates.
  - A line whose r_h is still high when r_v falls is also counted.
- ACCUM, when r_v = 0 -> DONE.
- DONE (one cycle):
  - Register o_sum = acc, o_pix_cnt, o_line_cnt.
  - o_frame_err = (pix != W*H) | (lines != H) | saturation.
  - o_sum_valid = 1 for exactly one cycle.
  - Next state: ACCUM (with clear, as from IDLE) if r_v = 1, otherwise IDLE. This supports a 1-cycle vertical blank.
- Latency: first clock edge sampling i_v_sync = 0 is edge k. o_sum_valid is high during the cycle after edge k+2 and the results update at that edge.
- r_h = 1 while r_v = 0, or while in IDLE, is ignored: no accumulation, no counting.
- Zero-pixel frame (v high, no h): o_sum = 0, o_pix_cnt = 0, o_frame_err = 1.
- Reset mid-frame: outputs clear immediately (asynchronous). No o_sum_valid for the interrupted frame or the frame in progress at release.
- Non-pulse outputs change only on the DONE transition or on reset.

Test Plan (P_IMG_WIDTH=4, P_IMG_HEIGHT=2, P_SUM_WIDTH=48 unless stated):
1. One frame, 2 lines x 4 pixels, i_data=3 -> single o_sum_valid pulse 3 edges after v falls; o_sum=24, o_pix_cnt=8, o_line_cnt=2, o_frame_err=0.
2. Same frame but line 2 has 3 pixels, data 1..7 -> o_sum=28, o_pix_cnt=7, o_line_cnt=2, o_frame_err=1.
3. P_SUM_WIDTH=32, full frame of i_data=32'hFFFF_FFFF -> o_sum=32'hFFFF_FFFF, o_frame_err=1.
4. i_h_sync pulses with data 100 while i_v_sync=0, then a normal frame of 3s -> o_sum=24; no extra o_sum_valid.
5. Assert i_rst_n low mid-frame, release with i_v_sync still high -> outputs 0, no o_sum_valid for that frame; next full frame of 2s -> o_sum=16, o_frame_err=0.
6. Back-to-back frames (data 1 then 5) separated by a 1-cycle v low -> two pulses with o_sum=8 then 40, both o_frame_err=0.

Source files
------------

// File: rtl/hadamard_frame_accumulator_if.sv
// Product stream from the dual-image Hadamard multiplier.
//
// Stream semantics: there is no ready/backpressure. v_sync is a level that
// stays high for the whole frame. h_sync marks data as a valid product in the
// same cycle. The consumer must take every beat in which h_sync is high.
//
// Signals:
//   v_sync  frame-active level
//   h_sync  pixel-valid qualifier for data
//   data    product sample, aligned with h_sync
// Modports:
//   master  producer side (drives the stream)
//   slave   consumer side (the frame accumulator)
interface hadamard_frame_accumulator_if #(
  parameter int P_INPUT_DATA_WIDTH = 32
);
  logic                          v_sync;
  logic                          h_sync;
  logic [P_INPUT_DATA_WIDTH-1:0] data;

  modport master (output v_sync, output h_sync, output data);
  modport slave  (input  v_sync, input  h_sync, input  data);
endinterface

// File: rtl/hadamard_frame_accumulator.sv
// Frame-level accumulator for the Hadamard product stream.
// It sums every valid product in a frame, which gives the inner product of
// the two images. It also counts pixels and lines. A frame whose pixel or line
// count is wrong, or whose sum saturated, is flagged as an error. Each frame
// produces one registered result with a single-cycle valid pulse.
//
// Ports:
//   i_clk, i_rst_n  clock; asynchronous active-low reset
//   prod            product stream (slave modport)
//   o_sum_valid     one-cycle pulse when a new frame result is presented
//   o_sum           frame sum, saturating, held until the next result
//   o_pix_cnt       valid pixels in the frame, saturating, held
//   o_line_cnt      lines in the frame, saturating, held
//   o_frame_err     held flag: count mismatch or saturation
//   o_busy          high while accumulating a frame
//   o_dbg_state     current FSM state (0 idle, 1 accum, 2 done)
module hadamard_frame_accumulator #(
  parameter int P_INPUT_DATA_WIDTH = 32,
  parameter int P_IMG_WIDTH        = 256,
  parameter int P_IMG_HEIGHT       = 256,
  parameter int P_SUM_WIDTH        = 48,
  localparam int PIX_W  = $clog2(P_IMG_WIDTH * P_IMG_HEIGHT + 1),
  localparam int LINE_W = $clog2(P_IMG_HEIGHT + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  hadamard_frame_accumulator_if.slave prod,
  output logic                      o_sum_valid,
  output logic [P_SUM_WIDTH-1:0]    o_sum,
  output logic [PIX_W-1:0]          o_pix_cnt,
  output logic [LINE_W-1:0]         o_line_cnt,
  output logic                      o_frame_err,
  output logic                      o_busy,
  output logic [1:0]                o_dbg_state
);

  localparam int SUM_W1 = P_SUM_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                          r_v, r_v_d, r_h, r_h_d;
  logic [P_INPUT_DATA_WIDTH-1:0] r_d;

  logic [P_SUM_WIDTH-1:0] acc;
  logic [PIX_W-1:0]       pix;
  logic [LINE_W-1:0]      line;
  logic                   sat;

  logic                   v_rise;
  logic                   frame_start, accum_en, line_en, publish;
  logic [SUM_W1-1:0]      sum_ext;

  // Input stage. Both v registers reset high, so a frame that is already
  // active when reset is released never looks like a rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v   <= 1'b1;
      r_v_d <= 1'b1;
      r_h   <= 1'b0;
      r_h_d <= 1'b0;
      r_d   <= '0;
    end else begin
      r_v   <= prod.v_sync;
      r_v_d <= r_v;
      r_h   <= prod.h_sync;
      r_h_d <= r_h;
      r_d   <= prod.data;
    end
  end

  assign v_rise = r_v & ~r_v_d;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (v_rise) state_nxt = ST_ACCUM;
      ST_ACCUM: if (!r_v)   state_nxt = ST_DONE;
      ST_DONE:  state_nxt = r_v ? ST_ACCUM : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    frame_start = 1'b0;
    accum_en    = 1'b0;
    line_en     = 1'b0;
    publish     = 1'b0;
    o_busy      = 1'b0;
    case (state)
      ST_IDLE: frame_start = v_rise;
      ST_ACCUM: begin
        o_busy   = 1'b1;
        accum_en = r_v & r_h;
        // A line ends on an h falling edge. If v drops while h was still
        // active, that open line is closed here as well.
        line_en  = r_h_d & (~r_h | ~r_v);
      end
      ST_DONE: begin
        publish     = 1'b1;
        frame_start = r_v;
      end
      default: ;
    endcase
  end

  assign o_dbg_state = state;

  // The extra top bit of the widened sum is the overflow carry.
  assign sum_ext = {1'b0, acc} + SUM_W1'(r_d);

  // Accumulator and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc  <= '0;
      pix  <= '0;
      line <= '0;
      sat  <= 1'b0;
    end else if (frame_start) begin
      acc  <= r_h ? P_SUM_WIDTH'(r_d) : '0;
      pix  <= r_h ? PIX_W'(1) : '0;
      line <= '0;
      sat  <= 1'b0;
    end else begin
      if (accum_en) begin
        if (sum_ext[P_SUM_WIDTH]) begin
          acc <= '1;
          sat <= 1'b1;
        end else begin
          acc <= sum_ext[P_SUM_WIDTH-1:0];
        end
        if (pix != '1) pix <= pix + PIX_W'(1);
      end
      if (line_en && line != '1) line <= line + LINE_W'(1);
    end
  end

  // Result registers, updated only when leaving DONE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum_valid <= 1'b0;
      o_sum       <= '0;
      o_pix_cnt   <= '0;
      o_line_cnt  <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_sum_valid <= publish;
      if (publish) begin
        o_sum       <= acc;
        o_pix_cnt   <= pix;
        o_line_cnt  <= line;
        o_frame_err <= (pix != PIX_W'(P_IMG_WIDTH * P_IMG_HEIGHT)) |
                       (line != LINE_W'(P_IMG_HEIGHT)) | sat;
      end
    end
  end

endmodule

// File: tb/tb_hadamard_frame_accumulator.sv
// Bench for hadamard_frame_accumulator with a 4x2 image. Two instances share
// one stream: a 48-bit sum and a 32-bit sum, so that saturation is observable.
// Expected frame results come from the pixel list of each frame, computed as
// plain totals and counts, and are queued for the monitors.
module tb_hadamard_frame_accumulator;
  localparam int W      = 4;
  localparam int H      = 2;
  localparam int DW     = 32;
  localparam int PIX_W  = $clog2(W * H + 1);
  localparam int LINE_W = $clog2(H + 1);
  localparam int PIX_MAX  = (1 << PIX_W) - 1;
  localparam int LINE_MAX = (1 << LINE_W) - 1;
  localparam int E48 = 1 + LINE_W + PIX_W + 48;
  localparam int E32 = 1 + LINE_W + PIX_W + 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hadamard_frame_accumulator_if #(.P_INPUT_DATA_WIDTH(DW)) prod ();

  logic              s48_valid, s48_err, s48_busy;
  logic [47:0]       s48_sum;
  logic [PIX_W-1:0]  s48_pix;
  logic [LINE_W-1:0] s48_line;
  logic [1:0]        s48_state;
  logic              s32_valid, s32_err, s32_busy;
  logic [31:0]       s32_sum;
  logic [PIX_W-1:0]  s32_pix;
  logic [LINE_W-1:0] s32_line;
  logic [1:0]        s32_state;

  hadamard_frame_accumulator #(
    .P_INPUT_DATA_WIDTH(DW), .P_IMG_WIDTH(W), .P_IMG_HEIGHT(H), .P_SUM_WIDTH(48)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .prod(prod),
    .o_sum_valid(s48_valid), .o_sum(s48_sum), .o_pix_cnt(s48_pix),
    .o_line_cnt(s48_line), .o_frame_err(s48_err), .o_busy(s48_busy),
    .o_dbg_state(s48_state)
  );

  hadamard_frame_accumulator #(
    .P_INPUT_DATA_WIDTH(DW), .P_IMG_WIDTH(W), .P_IMG_HEIGHT(H), .P_SUM_WIDTH(32)
  ) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .prod(prod),
    .o_sum_valid(s32_valid), .o_sum(s32_sum), .o_pix_cnt(s32_pix),
    .o_line_cnt(s32_line), .o_frame_err(s32_err), .o_busy(s32_busy),
    .o_dbg_state(s32_state)
  );

  // scoreboard
  logic [E48-1:0] exp48_q[$];
  logic [E32-1:0] exp32_q[$];
  int line_len[$];
  logic [DW-1:0] pix_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int pushed = 0;
  int got48 = 0, got32 = 0;
  int unexp48 = 0, unexp32 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: the sum of all pixels clamped to the sum width, counts clamped
  // to their counter widths, error on any count mismatch or clamp.
  function automatic void push_expected();
    logic [63:0]       total;
    int                np, nl;
    logic              sat48, sat32, base_err;
    logic [47:0]       e_s48;
    logic [31:0]       e_s32;
    logic [PIX_W-1:0]  e_ps;
    logic [LINE_W-1:0] e_ls;
    total = '0;
    np = pix_q.size();
    nl = line_len.size();
    foreach (pix_q[i]) total += 64'(pix_q[i]);
    sat48 = total > 64'h0000_FFFF_FFFF_FFFF;
    sat32 = total > 64'h0000_0000_FFFF_FFFF;
    e_s48 = sat48 ? '1 : total[47:0];
    e_s32 = sat32 ? '1 : total[31:0];
    e_ps  = PIX_W'((np > PIX_MAX) ? PIX_MAX : np);
    e_ls  = LINE_W'((nl > LINE_MAX) ? LINE_MAX : nl);
    base_err = (np != W * H) || (nl != H);
    exp48_q.push_back({base_err | sat48, e_ls, e_ps, e_s48});
    exp32_q.push_back({base_err | sat32, e_ls, e_ps, e_s32});
    pushed++;
  endfunction

  task automatic set_const(input int nl, input int len, input logic [DW-1:0] val);
    line_len.delete();
    pix_q.delete();
    for (int i = 0; i < nl; i++) begin
      line_len.push_back(len);
      for (int j = 0; j < len; j++) pix_q.push_back(val);
    end
  endtask

  task automatic set_rand(input int nl, input int maxlen);
    int len;
    line_len.delete();
    pix_q.delete();
    for (int i = 0; i < nl; i++) begin
      len = $urandom_range(1, maxlen);
      line_len.push_back(len);
      for (int j = 0; j < len; j++) pix_q.push_back($urandom);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      prod.v_sync = 1'b0;
      prod.h_sync = 1'($urandom_range(0, 1));
      prod.data   = $urandom;
      tick();
    end
    prod.h_sync = 1'b0;
  endtask

  // Drives the frame in line_len/pix_q. Expects v low already committed.
  // Ends after the first cycle with v low, optionally with a stray h pulse.
  task automatic drive_frame(input int pre, input bit junk_tail);
    int idx;
    idx = 0;
    prod.v_sync = 1'b1;
    prod.h_sync = 1'b0;
    repeat (pre) tick();
    for (int l = 0; l < line_len.size(); l++) begin
      for (int p = 0; p < line_len[l]; p++) begin
        prod.h_sync = 1'b1;
        prod.data   = pix_q[idx];
        idx++;
        tick();
      end
      if (l != line_len.size() - 1) begin
        repeat ($urandom_range(1, 2)) begin
          prod.h_sync = 1'b0;
          prod.data   = $urandom;
          tick();
        end
      end
    end
    prod.v_sync = 1'b0;
    prod.h_sync = junk_tail;
    prod.data   = $urandom;
    tick();
    prod.h_sync = 1'b0;
  endtask

  // monitors
  always @(negedge clk) begin
    logic [E48-1:0] e;
    if (s48_valid === 1'b1) begin
      got48++;
      if (exp48_q.size() > 0) begin
        e = exp48_q.pop_front();
        check("dut48 sum",  64'(s48_sum),  64'(e[47:0]));
        check("dut48 pix",  64'(s48_pix),  64'(e[48 +: PIX_W]));
        check("dut48 line", 64'(s48_line), 64'(e[48 + PIX_W +: LINE_W]));
        check("dut48 err",  64'(s48_err),  64'(e[E48-1]));
      end else begin
        unexp48++;
      end
    end
  end

  always @(negedge clk) begin
    logic [E32-1:0] e;
    if (s32_valid === 1'b1) begin
      got32++;
      if (exp32_q.size() > 0) begin
        e = exp32_q.pop_front();
        check("dut32 sum",  64'(s32_sum),  64'(e[31:0]));
        check("dut32 pix",  64'(s32_pix),  64'(e[32 +: PIX_W]));
        check("dut32 line", 64'(s32_line), 64'(e[32 + PIX_W +: LINE_W]));
        check("dut32 err",  64'(s32_err),  64'(e[E32-1]));
      end else begin
        unexp32++;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, " valid"}, 64'(s48_valid), 64'd0);
    check({tag, " sum"},   64'(s48_sum),   64'd0);
    check({tag, " pix"},   64'(s48_pix),   64'd0);
    check({tag, " line"},  64'(s48_line),  64'd0);
    check({tag, " err"},   64'(s48_err),   64'd0);
    check({tag, " busy"},  64'(s48_busy),  64'd0);
    check({tag, " sum32"}, 64'(s32_sum),   64'd0);
  endtask

  initial begin
    prod.v_sync = 1'b0;
    prod.h_sync = 1'b0;
    prod.data   = '0;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    idle(3);
    check_outputs_zero("post reset idle");

    // 1: full frame of 3s with latency check
    set_const(2, 4, 32'd3);
    push_expected();
    drive_frame(1, 1'b0);
    check("t1 valid at k",   64'(s48_valid), 64'd0);
    tick();
    check("t1 valid at k+1", 64'(s48_valid), 64'd0);
    tick();
    check("t1 valid at k+2", 64'(s48_valid), 64'd1);
    check("t1 sum",  64'(s48_sum),  64'd24);
    check("t1 pix",  64'(s48_pix),  64'd8);
    check("t1 line", 64'(s48_line), 64'd2);
    check("t1 err",  64'(s48_err),  64'd0);
    tick();
    check("t1 valid at k+3", 64'(s48_valid), 64'd0);
    idle(3);
    check("t1 sum held", 64'(s48_sum), 64'd24);
    check("t1 idle busy", 64'(s48_busy), 64'd0);

    // 2: short second line, data 1..7
    line_len.delete();
    pix_q.delete();
    line_len.push_back(4);
    line_len.push_back(3);
    for (int i = 1; i <= 7; i++) pix_q.push_back(DW'(i));
    push_expected();
    drive_frame(0, 1'b1);
    idle(4);

    // 3: all-ones data saturates the 32-bit sum only
    set_const(2, 4, 32'hFFFF_FFFF);
    push_expected();
    drive_frame(2, 1'b0);
    idle(4);
    check("t3 sum32", 64'(s32_sum), 64'hFFFF_FFFF);
    check("t3 err32", 64'(s32_err), 64'd1);

    // 4: h pulses outside any frame are ignored
    repeat (3) begin
      prod.v_sync = 1'b0;
      prod.h_sync = 1'b1;
      prod.data   = 32'd100;
      tick();
    end
    prod.h_sync = 1'b0;
    tick();
    set_const(2, 4, 32'd3);
    push_expected();
    drive_frame(1, 1'b0);
    idle(4);
    check("t4 sum", 64'(s48_sum), 64'd24);

    // 5: reset mid-frame, released while v is still high
    prod.v_sync = 1'b1;
    prod.h_sync = 1'b1;
    prod.data   = 32'd2;
    repeat (3) tick();
    check("t5 busy mid frame", 64'(s48_busy), 64'd1);
    rst_n = 1'b0;
    #1 check_outputs_zero("t5 async reset");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    prod.h_sync = 1'b0;
    tick();
    prod.v_sync = 1'b0;
    idle(6);
    check_outputs_zero("t5 ignored frame");
    set_const(2, 4, 32'd2);
    push_expected();
    drive_frame(1, 1'b0);
    idle(4);
    check("t5 sum", 64'(s48_sum), 64'd16);

    // 6: back-to-back frames with a single-cycle vertical blank
    set_const(2, 4, 32'd1);
    push_expected();
    drive_frame(0, 1'b0);
    set_const(2, 4, 32'd5);
    push_expected();
    drive_frame(0, 1'b1);
    idle(4);
    check("t6 sum", 64'(s48_sum), 64'd40);

    // zero-pixel frame
    line_len.delete();
    pix_q.delete();
    push_expected();
    drive_frame(3, 1'b0);
    idle(4);

    // counter saturation: 5 lines of 4
    set_const(5, 4, 32'd1);
    push_expected();
    drive_frame(1, 1'b0);
    idle(4);

    // randomized frames, some back to back
    for (int f = 0; f < 10; f++) begin
      if (f % 3 == 0) set_const(2, 4, $urandom);
      else            set_rand($urandom_range(1, 5), 5);
      push_expected();
      drive_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(8);
    check("dut48 queue drained", 64'(exp48_q.size()), 64'd0);
    check("dut32 queue drained", 64'(exp32_q.size()), 64'd0);
    check("dut48 pulse count", 64'(got48), 64'(pushed));
    check("dut32 pulse count", 64'(got32), 64'(pushed));
    check("dut48 unexpected pulses", 64'(unexp48), 64'd0);
    check("dut32 unexpected pulses", 64'(unexp32), 64'd0);
    check("final busy", 64'(s48_busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
